// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception/interrupt unit for the five-stage MIPS pipeline.
// Decides whether the Mem-stage instruction traps and drives the pipeline
// flush. Holds SR, Cause and EPC, and services mfc0/mtc0/eret issued from Mem.
module cp0_exc_unit #(
   parameter logic [31:0] PRID       = 32'h0000_2020,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pc_Mem,
   input  logic [4:0]  excCode_Mem,
   input  logic        ifBd_Mem,
   input  logic [5:0]  hwInt,
   input  logic        cp0We_Mem,
   input  logic [4:0]  cp0Addr_Mem,
   input  logic [31:0] cp0Wd_Mem,
   input  logic        eret_Mem,
   output logic [31:0] cp0Rd_Mem,
   output logic        flush_Mem,
   output logic [31:0] excPc,
   output logic [31:0] epc
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   // SR fields
   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   // Cause fields; cause_ip is the second synchronizer flop
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   // EPC is word aligned, so only bits [31:2] are stored
   logic [29:0] epc_hi;
   // first synchronizer flop for hwInt
   logic [5:0]  int_sync1;

   logic        int_req;
   logic        exc_req;
   logic [31:0] epc_trap;

   // Trap request decode: interrupt needs a real instruction and no eret.
   always_comb begin
      int_req   = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl
                  & (pc_Mem != '0) & ~eret_Mem;
      exc_req   = (excCode_Mem != '0) & ~sr_exl;
      flush_Mem = int_req | exc_req;
      epc_trap  = ifBd_Mem ? (pc_Mem - 32'd4) : pc_Mem;
   end

   // Two-flop synchronizer for the level-sensitive interrupt lines.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         int_sync1 <= '0;
         cause_ip  <= '0;
      end else begin
         int_sync1 <= hwInt;
         cause_ip  <= int_sync1;
      end
   end

   // CP0 register updates: trap entry, then mtc0, then eret.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr_im     <= '0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_exc <= '0;
         epc_hi    <= '0;
      end else if (flush_Mem) begin
         sr_exl    <= 1'b1;
         cause_bd  <= ifBd_Mem;
         epc_hi    <= epc_trap[31:2];
         cause_exc <= int_req ? 5'd0 : excCode_Mem;
      end else if (cp0We_Mem) begin
         if (cp0Addr_Mem == ADDR_SR) begin
            sr_im  <= cp0Wd_Mem[15:10];
            sr_exl <= cp0Wd_Mem[1];
            sr_ie  <= cp0Wd_Mem[0];
         end else if (cp0Addr_Mem == ADDR_EPC) begin
            epc_hi <= cp0Wd_Mem[31:2];
         end
      end else if (eret_Mem) begin
         sr_exl <= 1'b0;
      end
   end

   // mfc0 read mux; unused bits and unmapped registers read zero.
   always_comb begin
      cp0Rd_Mem = '0;
      unique case (cp0Addr_Mem)
         ADDR_SR:    cp0Rd_Mem = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
         ADDR_CAUSE: cp0Rd_Mem = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
         ADDR_EPC:   cp0Rd_Mem = {epc_hi, 2'b00};
         ADDR_PRID:  cp0Rd_Mem = PRID;
         default:    cp0Rd_Mem = '0;
      endcase
   end

   assign excPc = HANDLER_PC;
   assign epc   = {epc_hi, 2'b00};

endmodule
